// File: rtl/eq_pkg.sv
// Shared equalizer constants and types for the folded symmetric FIR bands.
package eq_pkg;
  localparam int FILTER_SIZE = 26;
  localparam int COEF_WIDTH  = 16;
  localparam int ACC_WIDTH   = 56;
  localparam int SAMPLE_DIV  = 128;

  typedef logic signed [COEF_WIDTH+1:0] coef_t;
  typedef enum logic {IDLE, MAC} state_t;
endpackage

// File: rtl/fir_hist_buf.sv
// Circular sample history with two combinational taps addressed relative to
// the write pointer: the newer and older sample of folded pair k.
module fir_hist_buf #(
  parameter int DEPTH = 51,
  parameter int KW    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic signed [31:0] wdata,
  input  logic [KW-1:0]      k,
  output logic signed [31:0] rd_new,
  output logic signed [31:0] rd_old
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEP = (AW+1)'(DEPTH);

  logic signed [31:0] mem [DEPTH];
  logic [AW-1:0] wptr, idx_new, idx_old;
  logic [AW:0]   raw_new, raw_old;

  // wptr is one past the newest sample, so newest-k sits at wptr-1-k and the
  // oldest-of-window partner sits at wptr+k (both mod DEPTH).
  always_comb begin
    raw_new = {1'b0, wptr} + DEP - (AW+1)'(1) - (AW+1)'(k);
    raw_old = {1'b0, wptr} + (AW+1)'(k);
    idx_new = AW'((raw_new >= DEP) ? raw_new - DEP : raw_new);
    idx_old = AW'((raw_old >= DEP) ? raw_old - DEP : raw_old);
  end

  assign rd_new = mem[idx_new];
  assign rd_old = mem[idx_old];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wptr] <= wdata;
      wptr      <= (wptr == AW'(DEPTH-1)) ? '0 : wptr + AW'(1);
    end
  end
endmodule

// File: rtl/fir_mac_sched.sv
// Time-multiplexed symmetric FIR: one folded tap pair per cycle through a
// single MAC, with a runtime-writable coefficient file.
module fir_mac_sched #(
  parameter int FILTER_SIZE = eq_pkg::FILTER_SIZE,
  parameter int COEF_WIDTH  = eq_pkg::COEF_WIDTH,
  parameter int ACC_WIDTH   = eq_pkg::ACC_WIDTH,
  parameter int SAMPLE_DIV  = eq_pkg::SAMPLE_DIV
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [31:0]             d_in,
  output logic signed [31:0]             d_out,
  output logic                           out_valid,
  input  logic                           coef_we,
  input  logic [$clog2(FILTER_SIZE)-1:0] coef_addr,
  input  logic signed [COEF_WIDTH+1:0]   coef_wdata,
  output logic                           coef_err
);
  import eq_pkg::*;

  localparam int N  = 2*FILTER_SIZE-1;
  localparam int KW = $clog2(FILTER_SIZE);
  localparam int PW = 33+COEF_WIDTH+2;
  localparam logic signed [31:0] DIV = 32'(SAMPLE_DIV);

  state_t state, nxt;
  logic [KW-1:0] k;
  logic signed [ACC_WIDTH-1:0] acc, sum;
  logic signed [COEF_WIDTH+1:0] coef [FILTER_SIZE];
  logic signed [31:0] scaled, rd_new, rd_old;
  logic signed [32:0] pre;
  logic signed [PW-1:0] prod;
  logic hs, last;

  assign hs     = in_valid && in_ready;
  assign last   = (k == KW'(FILTER_SIZE-1));
  assign scaled = d_in / DIV;

  fir_hist_buf #(.DEPTH(N), .KW(KW)) u_hist (
    .clk    (clk),
    .rst    (rst),
    .we     (hs),
    .wdata  (scaled),
    .k      (k),
    .rd_new (rd_new),
    .rd_old (rd_old)
  );

  // Both taps alias the same entry at the centre, so it is added only once.
  always_comb begin
    pre  = 33'(rd_new) + (last ? 33'sd0 : 33'(rd_old));
    prod = PW'(pre) * PW'(coef[k]);
    sum  = acc + ACC_WIDTH'(prod);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (in_valid) nxt = MAC;
      MAC:  if (last)     nxt = IDLE;
      default:            nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      k         <= '0;
      d_out     <= '0;
      out_valid <= 1'b0;
      coef_err  <= 1'b0;
      for (int i = 0; i < FILTER_SIZE; i++) coef[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      coef_err  <= 1'b0;
      if (coef_we) begin
        if (state == IDLE && int'(coef_addr) < FILTER_SIZE) coef[coef_addr] <= coef_wdata;
        else coef_err <= 1'b1;
      end
      if (hs) begin
        acc <= '0;
        k   <= '0;
      end else if (state == MAC) begin
        if (last) begin
          d_out     <= sum[31:0];
          out_valid <= 1'b1;
        end else begin
          acc <= sum;
          k   <= k + KW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_fir_mac_sched.sv
// Bench for fir_mac_sched: per-cycle comparison against a direct-form
// convolution model plus table vectors and directed corner sequences.
module tb_fir_mac_sched;
  localparam int FS = 26;
  localparam int N  = 2*FS-1;

  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, coef_we = 1'b0;
  logic in_ready, out_valid, coef_err;
  logic signed [31:0] d_in = '0;
  logic signed [31:0] d_out;
  logic [4:0] coef_addr = '0;
  logic signed [17:0] coef_wdata = '0;

  always #5 clk = ~clk;

  fir_mac_sched dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .d_in       (d_in),
    .d_out      (d_out),
    .out_valid  (out_valid),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .coef_err   (coef_err)
  );

  int vecs = 0, errs = 0, cyc = 0, ov_cnt = 0, err_cnt = 0;
  longint xs [N];
  longint mc [FS];
  typedef struct { int due; logic [31:0] val; } pend_t;
  pend_t pq [$];
  int hs_cyc [$];
  logic [31:0] last_out = '0;
  bit m_idle = 1'b1, last_hs = 1'b0;

  typedef struct { logic signed [31:0] din; logic signed [17:0] c0; logic signed [31:0] exp; } vec_t;
  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, got, exp);
    end
  endtask

  // y[n] = sum over all 2*FS-1 taps of h[j]*x[n-j], with h symmetric about FS-1
  function automatic logic [31:0] model_y();
    longint y = 0;
    for (int j = 0; j < N; j++) y += mc[(j < FS) ? j : N-1-j] * xs[j];
    return y[31:0];
  endfunction

  task automatic model_clear();
    foreach (xs[i]) xs[i] = 0;
    foreach (mc[i]) mc[i] = 0;
    pq.delete();
    last_out = '0;
    m_idle = 1'b1;
  endtask

  task automatic step();
    bit s_rst, s_we, s_hs, exp_ov, exp_err;
    logic [4:0] s_a;
    logic signed [17:0] s_w;
    logic signed [31:0] s_d;
    pend_t p;
    s_rst = rst; s_we = coef_we; s_hs = in_valid && m_idle;
    s_a = coef_addr; s_w = coef_wdata; s_d = d_in;
    exp_ov = 1'b0; exp_err = 1'b0; last_hs = 1'b0;
    @(posedge clk); #1; cyc++;
    if (s_rst) model_clear();
    else begin
      if (s_we) begin
        if (m_idle) mc[s_a] = longint'(s_w);
        else exp_err = 1'b1;
      end
      if (s_hs) begin
        for (int i = N-1; i > 0; i--) xs[i] = xs[i-1];
        xs[0] = longint'(s_d / 128);
        p.due = cyc + FS; p.val = model_y();
        pq.push_back(p);
        hs_cyc.push_back(cyc);
        last_hs = 1'b1;
      end
      if (pq.size() > 0 && pq[0].due == cyc) begin
        exp_ov = 1'b1; last_out = pq[0].val; void'(pq.pop_front());
      end
      m_idle = !(pq.size() > 0 && pq[0].due > cyc);
    end
    if (out_valid) ov_cnt++;
    if (coef_err) err_cnt++;
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    chk("d_out", d_out, last_out);
    chk("coef_err", 32'(coef_err), 32'(exp_err));
    chk("in_ready", 32'(in_ready), 32'(m_idle));
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); rst = 1'b0;
  endtask

  task automatic wr_coef(input int a, input logic signed [17:0] w);
    coef_we = 1'b1; coef_addr = 5'(a); coef_wdata = w;
    step();
    coef_we = 1'b0;
  endtask

  task automatic send(input logic signed [31:0] v);
    int g = 0;
    in_valid = 1'b1; d_in = v;
    do begin step(); g++; end while (!last_hs && g < 200);
    in_valid = 1'b0;
    if (!last_hs) begin vecs++; errs++; $display("FAIL send_timeout: no handshake after %0d cycles", g); end
  endtask

  task automatic send_cw(input logic signed [31:0] v, input int a, input logic signed [17:0] w);
    coef_we = 1'b1; coef_addr = 5'(a); coef_wdata = w;
    in_valid = 1'b1; d_in = v;
    step();
    coef_we = 1'b0;
    if (!last_hs) send(v);
    else in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (!m_idle && g < 200) begin step(); g++; end
    if (!m_idle) begin vecs++; errs++; $display("FAIL idle_timeout: still busy after %0d cycles", g); end
  endtask

  task automatic load_ramp();
    for (int i = 0; i < FS; i++) wr_coef(i, 18'(i+1));
  endtask

  initial begin
    int cnt, g, ov0, e0;
    tbl[0] = '{-32'sd129,        18'sd1,      -32'sd1};
    tbl[1] = '{-32'sd127,        18'sd1,       32'sd0};
    tbl[2] = '{ 32'sd128,        18'sd1,       32'sd1};
    tbl[3] = '{ 32'sd127,        18'sd1,       32'sd0};
    tbl[4] = '{-32'sd128,        18'sd1,      -32'sd1};
    tbl[5] = '{ 32'sd1280,      -18'sd3,      -32'sd30};
    tbl[6] = '{-32'sd256,        18'sd5,      -32'sd10};
    tbl[7] = '{ 32'sh7FFFFFFF,   18'sd1,       32'sd16777215};
    tbl[8] = '{ 32'sh80000000,   18'sd1,      -32'sd16777216};
    tbl[9] = '{ 32'sd12800,      18'sd131071,  32'sd13107100};

    model_clear();
    step(); step(); rst = 1'b0;
    chk("reset_d_out", d_out, 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_coef_err", 32'(coef_err), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);

    // single-tap pre-scale vectors from cleared history
    for (int r = 0; r < 10; r++) begin
      do_reset();
      wr_coef(0, tbl[r].c0);
      send(tbl[r].din);
      wait_idle();
      chk($sformatf("tbl%0d", r), d_out, tbl[r].exp);
    end

    // impulse response 1..26..1
    do_reset();
    load_ramp();
    for (int j = 0; j < N; j++) begin
      send((j == 0) ? 32'sd128 : 32'sd0);
      wait_idle();
      chk($sformatf("impulse%0d", j), d_out, 32'((j < FS) ? j+1 : N-j));
    end

    // back-to-back with in_valid held
    hs_cyc.delete(); ov0 = ov_cnt; cnt = 0; g = 0;
    in_valid = 1'b1; d_in = $urandom;
    while (cnt < 10 && g < 1000) begin
      step(); g++;
      if (last_hs) begin cnt++; d_in = $urandom; end
    end
    in_valid = 1'b0;
    wait_idle();
    chk("b2b_count", cnt, 32'd10);
    for (int i = 1; i < 10; i++) chk("b2b_spacing", hs_cyc[i] - hs_cyc[i-1], 32'd27);
    chk("b2b_pulses", ov_cnt - ov0, 32'd10);

    // coefficient write while busy is dropped; in IDLE it lands
    do_reset();
    wr_coef(0, 18'sd5);
    e0 = err_cnt;
    send(32'sd1280);
    repeat (3) step();
    wr_coef(0, 18'sd7);
    wait_idle();
    chk("busy_err_pulses", err_cnt - e0, 32'd1);
    chk("busy_keep_old", d_out, 32'd50);
    wr_coef(0, 18'sd7);
    send(32'sd1280);
    wait_idle();
    chk("idle_write_new", d_out, 32'd70);

    // reset at MAC cycle 10
    do_reset();
    load_ramp();
    ov0 = ov_cnt;
    send(32'sd128);
    repeat (9) step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("midrst_d_out", d_out, 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    repeat (30) step();
    chk("midrst_no_pulse", ov_cnt - ov0, 32'd0);
    load_ramp();
    for (int j = 0; j < 4; j++) begin
      send((j == 0) ? 32'sd128 : 32'sd0);
      wait_idle();
      chk($sformatf("midrst_imp%0d", j), d_out, 32'(j+1));
    end

    // centre tap wraps past 32 bits
    do_reset();
    wr_coef(FS-1, 18'sd32767);
    for (int j = 0; j < FS; j++) begin send(32'sh7FFFFF80); wait_idle(); end
    chk("wrap", d_out, 32'hFEFF8001);

    // randomized traffic with interleaved coefficient writes
    do_reset();
    for (int i = 0; i < FS; i++) wr_coef(i, 18'($urandom));
    for (int t = 0; t < 40; t++) begin
      repeat ($urandom_range(0, 3)) step();
      case ($urandom_range(0, 3))
        0: send($urandom);
        1: send_cw($urandom, $urandom_range(0, FS-1), 18'($urandom));
        2: begin
             send($urandom);
             repeat ($urandom_range(1, 20)) step();
             wr_coef($urandom_range(0, FS-1), 18'($urandom));
           end
        default: begin
             wr_coef($urandom_range(0, FS-1), 18'($urandom));
             send($urandom);
           end
      endcase
      wait_idle();
    end
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/fir_mac_sched.md
# fir_mac_sched

Time-multiplexed sequencer for the equalizer's symmetric FIR bands. It holds the sample history, owns a runtime-writable coefficient file, and drives a single multiplier–accumulator through one folded tap pair per cycle. It replaces a fully parallel band filter wherever the sample rate leaves at least FILTER_SIZE+1 clocks per sample. It sits between the audio sample source and the band-gain mixer, with one instance per band.

## Interface

Parameters:
- FILTER_SIZE, 26: number of unique coefficients; the filter has 2*FILTER_SIZE-1 taps.
- COEF_WIDTH, 16: nominal coefficient width; stored coefficients are COEF_WIDTH+2 bits signed.
- ACC_WIDTH, 56: accumulator width, signed.
- SAMPLE_DIV, 128: input pre-scale divisor.

Ports:
- clk, in, 1: single clock; all state changes on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- in_valid, in, 1: a sample is offered on d_in.
- in_ready, out, 1: the block accepts a sample this cycle.
- d_in, in, 32: signed input sample.
- d_out, out, 32: signed filtered output, registered.
- out_valid, out, 1: one-cycle pulse; d_out holds a new result.
- coef_we, in, 1: coefficient write strobe.
- coef_addr, in, $clog2(FILTER_SIZE): coefficient index.
- coef_wdata, in, COEF_WIDTH+2: signed coefficient value.
- coef_err, out, 1: one-cycle pulse; the write was dropped.

## Operation

- Coefficient meaning: c[k] for k < FILTER_SIZE-1 multiplies the folded pair (x[n-k] + x[n-(2*FILTER_SIZE-2)+k]). c[FILTER_SIZE-1] multiplies the centre sample x[n-(FILTER_SIZE-1)].
- Sample acceptance: a handshake (in_valid & in_ready) writes d_in / SAMPLE_DIV into the history buffer as the newest sample x[n].
  - The division is a signed integer divide that truncates toward zero, stored as 32-bit signed.
- History buffer: 2*FILTER_SIZE-1 entries in a circular buffer.
  - The write pointer wraps from 2*FILTER_SIZE-2 to 0.
  - Entries that have never been written read as 0.
- State machine:
  - IDLE: in_ready=1. On handshake, store the sample, clear the accumulator, set k=0, and go to MAC.
  - MAC: in_ready=0. Each cycle, acc += c[k] * pair(k) and k++. On the cycle with k=FILTER_SIZE-1, the centre term is added, then d_out <= (acc + term)[31:0], out_valid <= 1, and the FSM goes to IDLE.
- Arithmetic widths:
  - Pre-add is 33-bit signed.
  - Product is 33+COEF_WIDTH+2 bits signed.
  - Accumulator is ACC_WIDTH bits; no saturation.
  - d_out is the low 32 bits of the final sum, wrapping.
- Coefficient writes: accepted only in IDLE, and take effect for the next accepted sample. coef_we in MAC drops the write and pulses coef_err the next cycle.
- Simultaneous coef_we and handshake in IDLE: both take effect, and the coefficient is used by this sample's computation.
- in_valid while in MAC: ignored. The source holds the sample until in_ready is seen.

## Timing

- Reset values:
  - d_out=0, out_valid=0, coef_err=0, in_ready=1 (IDLE).
  - All history entries, the write pointer, k, acc and all coefficients = 0.
- Reset mid-MAC: the computation is aborted, no out_valid pulse is produced, and the history is cleared.
- Latency: handshake at edge E0. MAC occupies edges E1..E_FILTER_SIZE. d_out and out_valid are updated at edge E_FILTER_SIZE and are visible in the following cycle.
- out_valid is high for exactly one cycle. in_ready is high in that same cycle, so back-to-back throughput is one sample per FILTER_SIZE+1 cycles.
- d_out holds its value until the next completed computation.

## Structure

- Shared package eq_pkg: FILTER_SIZE, COEF_WIDTH, SAMPLE_DIV, the coefficient type (signed [COEF_WIDTH+1:0]), and the state enum {IDLE, MAC}.
- One sub-module, fir_hist_buf: the circular history buffer with a write port and two combinational read ports (newer and older tap of a pair). The pair indices are computed relative to the write pointer, modulo 2*FILTER_SIZE-1.

## Test plan

- Impulse: after reset, write c[k]=k+1 for all k. Feed d_in=128, then zeros.
  - Outputs over 51 samples: 1, 2, …, 26, 25, …, 1.
  - Each output is 26 cycles after its handshake.
- Truncation of the pre-scale: with c[0]=1 and all others 0, feed d_in=-129 → d_out=-1, and d_in=-127 → d_out=0.
- Back-to-back: hold in_valid=1 for 10 samples.
  - Handshakes are spaced exactly 27 cycles apart.
  - out_valid pulses once per sample.
  - in_ready=0 throughout MAC.
- Coefficient write while busy: issue coef_we during MAC.
  - coef_err pulses once.
  - The next output reflects the old value.
  - The same write issued in IDLE changes the next output.
- Reset mid-operation: assert rst at MAC cycle 10.
  - No out_valid, d_out=0, in_ready=1 the next cycle.
  - The next impulse response starts from cleared history.
- Wrap and overflow: with c[25]=32767 and d_in=0x7FFFFF80 repeated, d_out equals the low 32 bits of the exact sum, with no saturation.
